// File: rtl/agg_feed.sv
// agg_feed: buffers PE-array partial sums in a small FIFO and streams exactly
// terms_q values per group onto agg_in, forcing agg_in to zero between terms.
module agg_feed #(
    parameter int unsigned agg_width  = 12,
    parameter int unsigned cnt_width  = 4,
    parameter int unsigned fifo_depth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [cnt_width-1:0] cfg_terms,
    input  logic                 in_valid,
    input  logic [agg_width-1:0] in_data,
    output logic                 in_ready,
    input  logic                 agg_ready,
    output logic [agg_width-1:0] agg_in,
    output logic                 agg_valid,
    output logic                 agg_last,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int unsigned occ_w = ptr_w + 1;
    localparam logic [occ_w-1:0] occ_full = occ_w'(fifo_depth);

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_run  = 2'd1;
    localparam logic [1:0] st_done = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [cnt_width-1:0] terms_q, terms_d;
    logic [cnt_width-1:0] acc_cnt, acc_cnt_d;
    logic [cnt_width-1:0] snd_cnt, snd_cnt_d;
    logic [cnt_width-1:0] snd_cnt_inc;
    logic [agg_width-1:0] agg_in_d;
    logic                 agg_valid_d;
    logic                 agg_last_d;
    logic                 busy_d;
    logic                 done_d;

    logic [agg_width-1:0] fifo_mem [fifo_depth];
    logic [ptr_w-1:0]     wr_ptr;
    logic [ptr_w-1:0]     rd_ptr;
    logic [occ_w-1:0]     occ;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [agg_width-1:0] fifo_head;

    // FIFO status and handshake qualifiers, all from registered state
    assign fifo_full   = (occ == occ_full);
    assign fifo_empty  = (occ == '0);
    assign fifo_head   = fifo_mem[rd_ptr];
    assign in_ready    = (state_q == st_run) && !fifo_full && (acc_cnt < terms_q);
    assign push        = in_valid && in_ready;
    assign pop         = (state_q == st_run) && !fifo_empty && agg_ready;
    assign snd_cnt_inc = snd_cnt + cnt_width'(1);

    // Next-state, counter and output-load logic
    always_comb begin
        state_d     = state_q;
        terms_d     = terms_q;
        acc_cnt_d   = acc_cnt;
        snd_cnt_d   = snd_cnt;
        agg_in_d    = '0;
        agg_valid_d = 1'b0;
        agg_last_d  = 1'b0;

        case (state_q)
            st_idle: begin
                if (start && (cfg_terms != '0)) begin
                    state_d   = st_run;
                    terms_d   = cfg_terms;
                    acc_cnt_d = '0;
                    snd_cnt_d = '0;
                end
            end
            st_run: begin
                if (push) begin
                    acc_cnt_d = acc_cnt + cnt_width'(1);
                end
                if (pop) begin
                    agg_in_d    = fifo_head;
                    agg_valid_d = 1'b1;
                    agg_last_d  = (snd_cnt_inc == terms_q);
                    snd_cnt_d   = snd_cnt_inc;
                    if (snd_cnt_inc == terms_q) begin
                        state_d = st_done;
                    end
                end
            end
            st_done: begin
                state_d = st_idle;
            end
            default: begin
                state_d = st_idle;
            end
        endcase

        busy_d = (state_d != st_idle);
        done_d = (state_d == st_done);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= st_idle;
            terms_q   <= '0;
            acc_cnt   <= '0;
            snd_cnt   <= '0;
            agg_in    <= '0;
            agg_valid <= 1'b0;
            agg_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            terms_q   <= terms_d;
            acc_cnt   <= acc_cnt_d;
            snd_cnt   <= snd_cnt_d;
            agg_in    <= agg_in_d;
            agg_valid <= agg_valid_d;
            agg_last  <= agg_last_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // FIFO storage; contents are don't-care once pointers are reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + occ_w'(1);
                2'b01:   occ <= occ - occ_w'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule
